// File: rtl/axicb_pkg.sv
// axicb_pkg: shared state type, response codes and R-slot field offsets
// for the crossbar master-side completion stages.
package axicb_pkg;

    typedef enum logic [1:0] {IDLE, FWD, DERR} rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // R slot layout is {rdata, rresp, rid} with rid at the LSB
    localparam int RID_LSB = 0;

    function automatic int rresp_lsb(input int id_w);
        return id_w;
    endfunction

    function automatic int rdata_lsb(input int id_w);
        return id_w + 2;
    endfunction

endpackage

// File: rtl/axicb_onehot_mux.sv
// axicb_onehot_mux: AND-OR selector of one W-bit lane out of N, driven by a
// one-hot select; an all-zero select yields zero.
module axicb_onehot_mux #(
    parameter int W = 1,
    parameter int N = 2
) (
    input  logic [N-1:0]   sel,
    input  logic [W*N-1:0] din,
    output logic [W-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) dout = dout | (din[i*W +: W] & {W{sel[i]}});
    end

endmodule

// File: rtl/axicb_mst_rd_cpl.sv
// axicb_mst_rd_cpl: master-side read completion; forwards the granted slave R
// channel or synthesizes DECERR beats. Optional AXICB_RD_LEN_CHECK_EN adds len_err.
module axicb_mst_rd_cpl
    import axicb_pkg::*;
#(
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 64,
    parameter int SLV_NB     = 4,
    parameter int CCH_W      = AXI_DATA_W + 2 + AXI_ID_W
) (
`ifdef AXICB_RD_LEN_CHECK_EN
    output logic                    len_err,
`endif
    input  logic                    aclk,
    input  logic                    srst,
    input  logic                    c_vld,
    input  logic [SLV_NB-1:0]       c_grant,
    input  logic                    c_mr,
    input  logic [7:0]              c_len,
    input  logic [AXI_ID_W-1:0]     c_id,
    output logic                    c_en,
    output logic                    c_ready,
    input  logic [SLV_NB-1:0]       slv_rvalid,
    output logic [SLV_NB-1:0]       slv_rready,
    input  logic [SLV_NB-1:0]       slv_rlast,
    input  logic [CCH_W*SLV_NB-1:0] slv_rch,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [AXI_ID_W-1:0]     rid,
    output logic [1:0]              rresp,
    output logic [AXI_DATA_W-1:0]   rdata,
    output logic                    rlast
);

    localparam int RRESP_LSB = rresp_lsb(AXI_ID_W);
    localparam int RDATA_LSB = rdata_lsb(AXI_ID_W);

    rd_state_t             state, nstate;
    logic [SLV_NB-1:0]     grant_q;
    logic [7:0]            len_q, cnt;
    logic [AXI_ID_W-1:0]   id_q;
    logic [CCH_W-1:0]      slot;
    logic                  sel_last, hs, cnt_step;

    axicb_onehot_mux #(.W(CCH_W), .N(SLV_NB)) u_rch_mux (
        .sel  (grant_q),
        .din  (slv_rch),
        .dout (slot)
    );

    axicb_onehot_mux #(.W(1), .N(SLV_NB)) u_rlast_mux (
        .sel  (grant_q),
        .din  (slv_rlast),
        .dout (sel_last)
    );

    assign hs = rvalid & rready;

`ifdef AXICB_RD_LEN_CHECK_EN
    assign cnt_step = hs & (state != IDLE);
`else
    assign cnt_step = hs & (state == DERR);
`endif

    always_comb begin
        nstate     = state;
        c_en       = 1'b0;
        c_ready    = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rresp      = RESP_OKAY;
        rdata      = '0;
        rid        = '0;
        slv_rready = '0;
        if (state == IDLE) begin
            nstate = !c_vld ? IDLE : c_mr ? DERR : |c_grant ? FWD : IDLE;
        end else if (state == FWD) begin
            rvalid     = |(slv_rvalid & grant_q);
            rid        = slot[RID_LSB +: AXI_ID_W];
            rresp      = slot[RRESP_LSB +: 2];
            rdata      = slot[RDATA_LSB +: AXI_DATA_W];
            rlast      = sel_last;
            slv_rready = grant_q & {SLV_NB{rready}};
            c_ready    = rready;
            c_en       = hs & rlast;
            nstate     = (hs & rlast) ? IDLE : FWD;
        end else begin
            rvalid  = 1'b1;
            rresp   = RESP_DECERR;
            rid     = id_q;
            rlast   = (cnt == len_q);
            c_ready = rready;
            c_en    = hs & rlast;
            nstate  = (hs & rlast) ? IDLE : DERR;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state   <= IDLE;
            grant_q <= '0;
            len_q   <= '0;
            id_q    <= '0;
            cnt     <= '0;
        end else begin
            state <= nstate;
            if (state == IDLE && c_vld) begin
                grant_q <= c_grant;
                len_q   <= c_len;
                id_q    <= c_id;
            end
            if (cnt_step) cnt <= rlast ? 8'd0 : cnt + 8'd1;
        end
    end

`ifdef AXICB_RD_LEN_CHECK_EN
    // sticky: a forwarded burst whose RLAST disagrees with the granted ALEN
    always_ff @(posedge aclk) begin
        if (srst) len_err <= 1'b0;
        else if (state == FWD && hs && (rlast != (cnt == len_q))) len_err <= 1'b1;
    end
`endif

endmodule

// File: doc/axicb_mst_rd_cpl.md
Name: axicb_mst_rd_cpl

Overview:
- Read-completion stage directly downstream of the per-master out-of-order completion arbiter.
- Consumes the granted completion attributes: slave one-hot, misroute flag, ALEN and ID.
- Routes the granted slave's R channel onto the master R interface, with zero-latency pass-through.
- For misrouted reads, synthesizes ALEN+1 DECERR beats itself.
- Pulses the arbiter enable once per finished burst, so grants stay stable for the whole burst.

Parameters:
- AXI_ID_W, 8, ID width in bits.
- AXI_DATA_W, 64, R data width in bits.
- SLV_NB, 4, number of slaves.
- CCH_W, AXI_DATA_W+2+AXI_ID_W, width of one slave R slot, packed {rdata, rresp, rid} with rid at LSB.

Ports:
- aclk  in  1  clock.
- srst  in  1  reset, synchronous, active-high; one clock domain only.
- c_vld  in  1  grant attributes valid; arbiter has a non-empty granted ID.
- c_grant  in  SLV_NB  granted slave, one-hot.
- c_mr  in  1  granted request was misrouted.
- c_len  in  8  granted ALEN.
- c_id  in  AXI_ID_W  granted ID.
- c_en  out  1  arbiter enable pulse.
- c_ready  out  1  master-side R handshake qualifier back to the arbiter (FIFO pull).
- slv_rvalid  in  SLV_NB  per-slave RVALID.
- slv_rready  out  SLV_NB  per-slave RREADY.
- slv_rlast  in  SLV_NB  per-slave RLAST.
- slv_rch  in  CCH_W*SLV_NB  per-slave R payload.
- rvalid  out  1  master RVALID.
- rready  in  1  master RREADY.
- rid  out  AXI_ID_W  master RID.
- rresp  out  2  master RRESP.
- rdata  out  AXI_DATA_W  master RDATA.
- rlast  out  1  master RLAST.

Behaviour:
- Reset (srst=1, any state, mid-burst included):
  - Next cycle: state=IDLE, beat counter=0, latched attributes=0, c_en=0.
  - All combinational outputs are then 0: rvalid, slv_rready, c_ready, rlast, rresp, rdata, rid.
- States: IDLE, FWD, DERR.
- IDLE:
  - All master/slave outputs are 0.
  - On c_vld=1, latch c_grant, c_len and c_id.
  - Next state is DERR if c_mr=1, else FWD if c_grant is non-zero.
  - c_vld=1 with c_grant=0 and c_mr=0 is ignored; stay in IDLE.
  - One cycle of entry latency.
- FWD (pure combinational pass-through of the latched slave, no bubble between beats):
  - rvalid = |(slv_rvalid & grant_q).
  - {rdata, rresp, rid} and rlast are taken from the selected slot.
  - slv_rready = grant_q & {SLV_NB{rready}}.
  - c_ready = rready.
  - On rvalid & rready & rlast: c_en=1 (combinational, same cycle), next state IDLE.
  - Non-last beats do not change state.
- DERR:
  - rvalid=1, rresp=2'b11, rdata=0, rid=id_q.
  - rlast=1 when cnt==len_q.
  - On rvalid & rready, cnt increments.
  - On the last handshake: c_en=1, cnt cleared, next state IDLE.
  - slv_rready=0 and c_ready=1&rready throughout (the arbiter FIFO still pulls on the last beat).
  - len_q=255 produces 256 beats; cnt is 8-bit and does not wrap before the last beat.
- c_en is 0 in every cycle except the final-beat handshake cycle. At most one pulse per burst.
- Inputs c_* are ignored outside IDLE, so a grant change mid-burst has no effect.
- rready low holds all master outputs stable. AXI valid-stability holds; rvalid never drops without a handshake in DERR.
- Back-to-back bursts: IDLE is always visited, giving a minimum of 1 idle cycle between bursts.

Optional Feature:
- Macro: AXICB_RD_LEN_CHECK_EN.
- When defined:
  - FWD also counts beats.
  - If rlast arrives at cnt≠len_q, or cnt reaches len_q without rlast, a sticky output len_err (1 bit) is set; only srst clears it.
  - Data forwarding is unaffected.
- When undefined: no counter in FWD, no len_err port, and cnt is used only in DERR.

Decomposition:
- Shared package axicb_pkg holds:
  - state enum typedef (IDLE/FWD/DERR);
  - RESP_DECERR=2'b11 and RESP_OKAY=2'b00;
  - slot field offset constants for {rdata, rresp, rid}.
- One sub-module is natural: axicb_onehot_mux, a parameterized one-hot AND-OR selector for slv_rch and slv_rlast, reusable by the write-response stage.

Test Plan:
- Normal burst:
  - Stimulus: c_vld=1, c_grant=4'b0100, c_mr=0, c_len=3; slave 2 sends 4 beats, last on beat 4; rready=1.
  - Response: 4 master beats with slave-2 data/ID; slv_rready=4'b0100; c_en=1 only on beat 4; IDLE next cycle.
- Misroute:
  - Stimulus: c_mr=1, c_len=2, c_id=8'h05.
  - Response: 3 beats with rresp=2'b11, rdata=0, rid=8'h05; rlast on beat 3 only; c_en=1 once; slv_rready=0 throughout.
- Backpressure:
  - Stimulus: DERR with c_len=1; rready toggles 0,1,0,1.
  - Response: rvalid stays 1; outputs stable while rready=0; exactly 2 handshakes; cnt never exceeds 1.
- Reset mid-burst:
  - Stimulus: assert srst on beat 2 of a 6-beat FWD burst.
  - Response: next cycle IDLE with rvalid=0, slv_rready=0, c_en=0; a new grant is accepted normally afterwards.
- Max length:
  - Stimulus: c_mr=1, c_len=255.
  - Response: 256 beats; rlast only on beat 256; a single c_en pulse.
- Length check (AXICB_RD_LEN_CHECK_EN):
  - Stimulus: c_len=3; slave asserts rlast on beat 2.
  - Response: burst terminates after beat 2; len_err=1 and stays 1 until srst.
